// File: rtl/shift_univ_burst.sv
// Universal shift register with hold, right/left shift and parallel load.
// A burst engine runs a counted sequence of shifts, with optional rotation.
module shift_univ_burst #(
  parameter int                WIDTH     = 8,
  parameter int                LEN_W     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             dir,
  input  logic [LEN_W-1:0] len,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               dir_reg, dir_next;
  logic               rot_reg, rot_next;

  logic               burst_rot;
  logic               s_r, s_l;
  logic [WIDTH-1:0]   shr, shl;

  // Rotation feeds the outgoing bit back in; otherwise the serial pins feed the shift.
  assign burst_rot = (state_reg == SHIFT) && rot_reg;
  assign s_r       = burst_rot ? q_reg[0]       : sin_r;
  assign s_l       = burst_rot ? q_reg[WIDTH-1] : sin_l;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shr[gi]   = q_reg[gi+1];
      assign shl[gi+1] = q_reg[gi];
    end
  endgenerate

  assign shr[WIDTH-1] = s_r;
  assign shl[0]       = s_l;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      q_reg     <= RESET_VAL;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dir_reg   <= 1'b0;
      rot_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      dir_reg   <= dir_next;
      rot_reg   <= rot_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    dir_next   = dir_reg;
    rot_next   = rot_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          // A burst request wins over any manual op issued in the same cycle.
          dir_next = dir;
          rot_next = rot;
          cnt_next = len;
          if (len != '0) begin
            state_next = SHIFT;
            busy_next  = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end else if (en) begin
          case (mode)
            MODE_HOLD:  q_next = q_reg;
            MODE_RIGHT: q_next = shr;
            MODE_LEFT:  q_next = shl;
            MODE_LOAD:  q_next = pin;
            default:    q_next = q_reg;
          endcase
        end
      end
      SHIFT: begin
        q_next   = dir_reg ? shl : shr;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == LEN_W'(1)) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign q      = q_reg;
  assign cnt    = cnt_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign sout_r = q_reg[0];
  assign sout_l = q_reg[WIDTH-1];

endmodule

// File: doc/shift_univ_burst.md
Name: shift_univ_burst

Overview:
- Parametrised universal shift register: hold, shift right, shift left and parallel load.
- Adds an autonomous burst engine that performs a programmed number of shifts, with an optional rotate mode, busy/done status and a shift count.
- Serves as the common serializer/deserializer element for serial links and bit-serial datapaths. Replaces the fixed 4-bit serial-in/serial-out shifter.

Parameters:
WIDTH, 8, register width in bits (>=2)
LEN_W, 4, width of the burst length field; burst length range 0..2^LEN_W-1
RESET_VAL, 0, value of q after reset (WIDTH bits)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
en  in  1  enables manual operation in IDLE
mode  in  2  manual op: 00 hold, 01 shift right, 10 shift left, 11 parallel load
sin_r  in  1  serial input; enters q[WIDTH-1] on a right shift
sin_l  in  1  serial input; enters q[0] on a left shift
pin  in  WIDTH  parallel load data
start  in  1  burst request, sampled in IDLE only
dir  in  1  burst direction: 0 right, 1 left; sampled with start
len  in  LEN_W  burst shift count; sampled with start
rot  in  1  rotate mode for burst; sampled with start
q  out  WIDTH  register contents
sout_r  out  1  q[0] (combinational from q)
sout_l  out  1  q[WIDTH-1] (combinational from q)
busy  out  1  high while a burst is in progress
done  out  1  one-cycle pulse when a burst completes
cnt  out  LEN_W  shifts remaining in the current burst

Behaviour:
- Reset (rst=0, asynchronous): q=RESET_VAL, state=IDLE, busy=0, done=0, cnt=0. Applies immediately, including mid-burst; the burst is abandoned and done is not pulsed. Release is synchronous to clk.
- Shift definitions:
  - Right: q <= {s, q[WIDTH-1:1]}.
  - Left: q <= {q[WIDTH-2:0], s}.
  - Manual mode: s = sin_r (right) or sin_l (left).
  - Burst with rot=1: s = the bit shifted out (q[0] for right, q[WIDTH-1] for left).
  - Burst with rot=0: s = sin_r or sin_l, sampled every shift cycle.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 at edge k:
  - Latch dir and rot, set cnt=len. q is unchanged at edge k.
  - len!=0: go to SHIFT, busy=1 from edge k.
  - len==0: stay IDLE, busy stays 0, done=1 for the cycle after edge k.
- IDLE, start=0, en=1: apply mode at each edge. Parallel load sets q=pin.
- IDLE, start=0, en=0: q holds.
- start has priority over en/mode in the same cycle. The manual op is discarded.
- SHIFT: at each edge, shift once in the latched direction and decrement cnt.
  - On the edge where cnt goes 1->0: return to IDLE, busy=0, done=1 for exactly one cycle.
  - A burst of len N performs shifts at edges k+1..k+N. done is high during the cycle after edge k+N.
- During SHIFT, start, en, mode, pin, dir, len and rot are ignored. No retrigger.
- A new start may be accepted in the same cycle done is high, since the state is IDLE. Done then returns low at the next edge unless that burst has len=0.
- Bursts with len>WIDTH are legal:
  - rot=1 wraps the contents (len=WIDTH restores the original q).
  - rot=0 continues filling from the serial input.
- cnt reads 0 whenever in IDLE after a completed burst.
- All outputs except sout_r and sout_l are registered.

Test Plan:
- WIDTH=4, RESET_VAL=4'b1010: assert rst=0 mid-cycle -> q=1010, busy=0, done=0 immediately, without a clock edge.
- en=1, mode=11, pin=0110, then mode=01 with sin_r=1 for 2 clocks -> q=0110, 1011, 1101; sout_r follows q[0].
- Load 1000, start=1, dir=1, rot=1, len=3 -> busy high 3 cycles; q=0001, 0010, 0100; done pulses one cycle after the third shift; cnt 3,2,1,0.
- Load 0001, start with dir=0, rot=0, len=6, sin_r=1 throughout, while driving en=1, mode=11 during the burst -> q=1111 after 6 shifts, the load is ignored, one done pulse.
- start=1 with len=0 -> done=1 next cycle, busy never high, q unchanged. start and en=1, mode=11 in the same cycle -> no load occurs.
- Burst len=5 with rst pulsed low after 2 shifts -> q=RESET_VAL, IDLE, no done pulse. A subsequent start with len=1 works normally.
